// File: rtl/aes_key_schedule_pkg.sv
// Shared AES-128 constants: key-expansion sizes, Rcon, S-box and FSM encoding.
// The S-box table is also used by the round datapath's byte substitution.
package aes_key_schedule_pkg;

  localparam int AES_NB = 4;
  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef logic [127:0] aes_key_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  // Rcon[1..10] stored at index 0..9
  localparam logic [7:0] RCON [AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_schedule_sub_word.sv
// SubWord: four independent S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_key_schedule_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // byte-wise substitution, byte 0 in the MSBs
  always_comb begin
    o_word = {sbox_lookup(i_word[31:24]), sbox_lookup(i_word[23:16]),
              sbox_lookup(i_word[15:8]),  sbox_lookup(i_word[7:0])};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// store, read combinationally by index.
//
//   state  | meaning
//   IDLE   | reset state, no keys held
//   EXPAND | generating round keys 1..10, one per clock
//   READY  | all 11 round keys held and readable
module aes_key_schedule
  import aes_key_schedule_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] round_key
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_keys_valid;
  aes_key_t    r_store [NUM_ROUNDS+1];

  logic [3:0]  w_prev_idx;
  aes_key_t    w_prev_key;
  logic [7:0]  w_rcon;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;
  aes_key_t    w_next_key;

  // previous key and Rcon for the round being generated (r_cnt = 1..10 in EXPAND)
  always_comb begin
    w_prev_idx = r_cnt - 4'd1;
    w_prev_key = '0;
    w_rcon     = 8'h00;
    if (w_prev_idx <= LAST_IDX) w_prev_key = r_store[w_prev_idx];
    if (r_cnt >= 4'd1 && r_cnt <= LAST_IDX) w_rcon = RCON[w_prev_idx];
    w_rot = {w_prev_key[23:0], w_prev_key[31:24]};
  end

  aes_sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  // one AES-128 expansion step: w0..w3 chained through the rotated/substituted w3
  always_comb begin
    w_temp     = w_sub ^ {w_rcon, 24'h0};
    w_w0       = w_prev_key[127:96] ^ w_temp;
    w_w1       = w_prev_key[95:64]  ^ w_w0;
    w_w2       = w_prev_key[63:32]  ^ w_w1;
    w_w3       = w_prev_key[31:0]   ^ w_w2;
    w_next_key = {w_w0, w_w1, w_w2, w_w3};
  end

  // sequencing FSM and key store; start is ignored while expanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
      for (int i = 0; i < NUM_ROUNDS + 1; i++) r_store[i] <= '0;
    end else begin
      case (r_state)
        IDLE, READY: begin
          if (start) begin
            r_store[0]   <= key_in;
            r_cnt        <= 4'd1;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
            r_state      <= EXPAND;
          end
        end
        EXPAND: begin
          r_store[r_cnt] <= w_next_key;
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == LAST_IDX) begin
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b1;
            r_state      <= READY;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // combinational read; out-of-range indices return zero
  always_comb begin
    round_key = '0;
    if (rk_idx <= LAST_IDX) round_key = r_store[rk_idx];
  end

  assign busy       = r_busy;
  assign keys_valid = r_keys_valid;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed-vector bench for aes_key_schedule using FIPS-197 and all-zero keys.
module tb_aes_key_schedule;

  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  aes_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .round_key  (round_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, input string tag, input logic [127:0] exp);
    rk_idx = idx;
    #1;
    chk(tag, round_key, exp);
  endtask

  // called at a negedge; start is seen by exactly one rising edge
  task automatic do_start(input logic [127:0] key);
    start  = 1'b1;
    key_in = key;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // counts busy cycles from the negedge after T0, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    rk_idx = 4'd0;
    #1;
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_valid", {127'b0, keys_valid}, 128'd0);
    read_rk(4'd0, "reset_rk0", 128'h0);
    read_rk(4'd10, "reset_rk10", 128'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 key expansion
    do_start(KEY_FIPS);
    count_busy(busy_cnt);
    chk("fips_busy_cycles", 128'(busy_cnt), 128'd10);
    chk("fips_valid", {127'b0, keys_valid}, 128'd1);
    read_rk(4'd0, "fips_rk0", KEY_FIPS);
    read_rk(4'd1, "fips_rk1", FIPS_RK1);
    read_rk(4'd10, "fips_rk10", FIPS_RK10);
    read_rk(4'd12, "fips_rk12", 128'h0);

    // restart from READY with the all-zero key
    do_start(128'h0);
    chk("restart_valid_drop", {127'b0, keys_valid}, 128'd0);
    chk("restart_busy", {127'b0, busy}, 128'd1);
    count_busy(busy_cnt);
    chk("zero_busy_cycles", 128'(busy_cnt), 128'd10);
    chk("zero_valid", {127'b0, keys_valid}, 128'd1);
    read_rk(4'd0, "zero_rk0", 128'h0);
    read_rk(4'd1, "zero_rk1", ZERO_RK1);
    read_rk(4'd10, "zero_rk10", ZERO_RK10);

    // second start while busy must be ignored
    rk_idx = 4'd12;
    do_start(KEY_FIPS);
    busy_cnt = 0;
    while (busy && busy_cnt < 40) begin
      busy_cnt++;
      if (busy_cnt == 3) begin
        start  = 1'b1;
        key_in = 128'h0;
      end else begin
        start = 1'b0;
      end
      if (busy_cnt == 5) chk("busy_rk12", round_key, 128'h0);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore_busy_cycles", 128'(busy_cnt), 128'd10);
    chk("ignore_valid", {127'b0, keys_valid}, 128'd1);
    read_rk(4'd1, "ignore_rk1", FIPS_RK1);
    read_rk(4'd10, "ignore_rk10", FIPS_RK10);

    // asynchronous reset during expansion
    do_start(128'h0);
    repeat (4) @(negedge clk);
    chk("mid_busy", {127'b0, busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", {127'b0, busy}, 128'd0);
    chk("async_valid", {127'b0, keys_valid}, 128'd0);
    for (int i = 0; i <= 10; i++) begin
      read_rk(4'(i), $sformatf("async_rk%0d", i), 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(KEY_FIPS);
    count_busy(busy_cnt);
    chk("post_rst_busy_cycles", 128'(busy_cnt), 128'd10);
    chk("post_rst_valid", {127'b0, keys_valid}, 128'd1);
    read_rk(4'd1, "post_rst_rk1", FIPS_RK1);
    read_rk(4'd10, "post_rst_rk10", FIPS_RK10);
    read_rk(4'd12, "post_rst_rk12", 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion. Sits directly upstream of the round datapath and supplies its current-round key input.
- Captures a 128-bit cipher key on start and derives round keys 1..10, one per clock, into an 11-entry store.
- The round controller then reads any round key by index.

Parameters:
- NUM_ROUNDS, 10, number of round keys generated after round key 0. Only 10 (AES-128) is legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; sampled high means capture key_in and begin expansion.
- key_in  input  128  cipher key. Bits [127:120] are byte 0 of FIPS-197 w0.
- busy  output  1  expansion in progress.
- keys_valid  output  1  all 11 round keys stored and readable.
- rk_idx  input  4  round key index, 0..10.
- round_key  output  128  stored key at rk_idx. Same byte order as key_in.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - busy=0, keys_valid=0, state IDLE, round counter=0.
  - All 11 key store entries cleared to 0, so round_key reads 0.
- FSM states:
  - IDLE: reset state, no keys.
  - EXPAND: generating.
  - READY: keys held.
- IDLE/READY with start=1 at edge T0:
  - store[0]<=key_in, counter<=1, busy<=1, keys_valid<=0, state EXPAND.
  - store[1..10] are not cleared.
- EXPAND, edge Tn (n=1..10):
  - store[n] <= f(store[n-1], Rcon[n]), counter increments.
  - f: temp = SubWord(RotWord(w3)) ^ {Rcon[n],24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- At edge T10 the last key is written, busy<=0, keys_valid<=1, state READY.
  - busy is high for exactly 10 cycles; keys_valid is high from the cycle after T10.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- start while busy: ignored. Expansion continues with the originally captured key.
- start in READY: restarts. keys_valid drops at T0, and round keys from the previous key are not trustworthy until keys_valid rises again.
- round_key is a combinational read of store[rk_idx], valid in any state. rk_idx 11..15 returns 128'h0.
  - Consumer reads only while keys_valid=1, though a stored entry n is stable from the cycle after Tn.
- Reset asserted mid-expansion: immediate return to the reset values above. No partial keys stay visible.
- start held high for multiple cycles: the first edge starts expansion. Later edges are ignored while busy.
  - If start is still high in READY, a restart occurs. The upstream rule is one-cycle pulses.

Decomposition:
- Shared package holds:
  - AES_NB=4, AES_NK=4, AES_NR=10.
  - The Rcon table as a 10x8 constant.
  - The S-box table constant, shared with the round datapath's byte substitution.
  - State encoding localparams IDLE/EXPAND/READY.
- One sub-module: aes_sub_word. Combinational, 32-bit in/out, four S-box lookups from the package table. Instantiated once, on the rotated w3.

Test Plan:
- Reset with rst_n=0 mid-run -> busy=0, keys_valid=0, round_key=0 for rk_idx 0..10, asynchronously, without waiting for a clk edge.
- start pulse, key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy high exactly 10 cycles, then keys_valid=1.
  - rk_idx=0: 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_idx=1: a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10: d014f9a8c9ee2589e13f0cc8b6630ca6.
- key_in=0 -> rk_idx=1 gives 62636363626363636263636362636363; rk_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- Second start pulse 3 cycles after the first, using a different key -> ignored. Final keys match the first key, and busy is still 10 cycles total.
- READY with FIPS key, then start with key 0 -> keys_valid drops next cycle and rises 10 cycles later. rk_idx=1 then reads 62636363626363636263636362636363.
- rst_n pulsed low at EXPAND cycle 5, then start with FIPS key -> clean full expansion, correct rk 10. rk_idx=12 reads 0 throughout.
